fp_accumulator: RTL and testbench
=================================

FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
REQ-001 The block SHALL have parameter C_OP, default fp_defs::C_OP, giving the operand width in bits.
REQ-002 The block SHALL have parameter C_EXP, default fp_defs::C_EXP, giving the exponent width.
REQ-003 The block SHALL have parameter C_MANT, default fp_defs::C_MANT, giving the stored mantissa width.
REQ-004 The block SHALL have parameter C_CNT, default 16, giving the beat-counter width.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port in_valid_i, input, 1 bit: an input beat is offered.
REQ-008 The block SHALL have port in_ready_o, output, 1 bit: the block accepts the offered beat.
REQ-009 The block SHALL have port in_data_i, input, C_OP bits: the FP operand {sign, exponent, mantissa}.
REQ-010 The block SHALL have port in_last_i, input, 1 bit: the beat is the final beat of its group.
REQ-011 The block SHALL have port out_valid_o, output, 1 bit: a group sum is presented.
REQ-012 The block SHALL have port out_ready_i, input, 1 bit: the downstream takes the sum.
REQ-013 The block SHALL have port out_data_o, output, C_OP bits: the accumulated FP sum.
REQ-014 The block SHALL have port out_count_o, output, C_CNT bits: the number of beats in the group.
REQ-015 The block SHALL have port busy_o, output, 1 bit: high while the state is not IDLE.

Function
REQ-016 A beat SHALL be accepted on a rising edge where in_valid_i and in_ready_o are both high; an output SHALL be consumed on a rising edge where out_valid_o and out_ready_i are both high.
REQ-017 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-018 IDLE + accepted beat SHALL load acc_q <= in_data_i with no addition and set cnt_q <= 1; next state is HOLD if in_last_i else ACCUM.
REQ-019 ACCUM + accepted beat SHALL set acc_q <= sum(acc_q, in_data_i) and cnt_q <= cnt_q+1; next state is HOLD if in_last_i else ACCUM.
REQ-020 ACCUM with no accepted beat SHALL hold acc_q and cnt_q unchanged.
REQ-021 In HOLD, out_valid_o SHALL be 1, out_data_o SHALL equal acc_q and out_count_o SHALL equal cnt_q, all stable until consumed.
REQ-022 HOLD + consume + no accepted beat SHALL go to IDLE.
REQ-023 HOLD + consume + accepted beat in the same cycle SHALL apply the IDLE load rule of REQ-018, so back-to-back groups have no bubble.
REQ-024 in_ready_o SHALL be 1 in IDLE and ACCUM, and equal out_ready_i in HOLD; this combinational path is intentional.
REQ-025 out_valid_o SHALL be 0 in IDLE and ACCUM.
REQ-026 Latency SHALL be one cycle: out_valid_o rises on the edge that accepts the last beat.
REQ-027 sum() SHALL be produced by one combinational instance of the team's FP adder, bit-exact with it: hidden bit = OR of the exponent bits, same pre-normalisation, same normalisation and truncation, sign taken from the adder.
REQ-028 There SHALL be no extra rounding, flag generation, or special handling of zero, infinity or NaN.
REQ-029 cnt_q SHALL saturate at 2^C_CNT-1; the sum SHALL keep accumulating after saturation.
REQ-030 A single-beat group (in_last_i on the first beat) SHALL pass in_data_i unchanged to out_data_o with out_count_o=1.
REQ-031 in_data_i and in_last_i SHALL be ignored when in_valid_i=0.

Reset
REQ-032 While rst_i=1, asynchronously, the state SHALL be IDLE, acc_q=0 and cnt_q=0.
REQ-033 During and after reset the outputs SHALL be: out_valid_o=0, out_data_o=0, out_count_o=0, busy_o=0, in_ready_o=1.
REQ-034 Reset mid-group or in HOLD SHALL discard the partial or pending sum; there is no output for that group.
REQ-035 The first beat accepted after release SHALL start a new group.

Verification
REQ-036 Beats 0x3C00, 0x4000, 0x4200 (last on the third), out_ready_i=1 -> out_data_o=0x4600, out_count_o=3, out_valid_o high for exactly one cycle, one cycle after the third beat.
REQ-037 Single beat 0x4100 with last=1 -> out_data_o=0x4100, out_count_o=1.
REQ-038 Beats 0x4100, 0xB800 (last), out_ready_i=0 for 5 cycles -> out_data_o=0x4000 held stable, in_ready_o=0 until out_ready_i=1.
REQ-039 Group ending 0x4600 in HOLD, out_ready_i=1 with a new beat 0x3C00 (last) in the same cycle -> next cycle out_data_o=0x3C00, out_count_o=1, with no IDLE cycle.
REQ-040 After 2 beats with no last, assert rst_i asynchronously -> outputs go to reset values immediately; a following group 0x3C00, 0x3C00 (last) yields 0x4000, count 2.
REQ-041 With C_CNT=2, send 5 beats of 0x3C00 -> out_count_o=3 (saturated) and out_data_o equal to the adder's bit-exact result.

Source files
------------

// File: rtl/fp_accumulator.sv
// Floating-point group accumulator: sums a stream of FP beats delimited by a last flag
// and presents each group sum with its beat count through a valid/ready output.

package fp_defs;
  localparam int C_OP   = 16;
  localparam int C_EXP  = 5;
  localparam int C_MANT = 10;
endpackage

// Combinational FP adder: align by truncating shift, add magnitudes, normalise by truncation.
module fp_add #(
  parameter int C_OP   = fp_defs::C_OP,
  parameter int C_EXP  = fp_defs::C_EXP,
  parameter int C_MANT = fp_defs::C_MANT
) (
  input  logic [C_OP-1:0] a,
  input  logic [C_OP-1:0] b,
  output logic [C_OP-1:0] sum
);
  logic              a_big;
  logic              sign_big, sign_small;
  logic [C_EXP-1:0]  e_big, e_small, e_diff, e_norm;
  logic [C_MANT:0]   m_big, m_small, m_align, m_norm;
  logic [C_MANT+1:0] m_sum;
  logic              found;
  int                lz;

  always_comb begin
    a_big      = a[C_OP-2:0] >= b[C_OP-2:0];
    sign_big   = a_big ? a[C_OP-1] : b[C_OP-1];
    sign_small = a_big ? b[C_OP-1] : a[C_OP-1];
    e_big      = a_big ? a[C_OP-2 -: C_EXP] : b[C_OP-2 -: C_EXP];
    e_small    = a_big ? b[C_OP-2 -: C_EXP] : a[C_OP-2 -: C_EXP];
    m_big      = a_big ? {|a[C_OP-2 -: C_EXP], a[C_MANT-1:0]} : {|b[C_OP-2 -: C_EXP], b[C_MANT-1:0]};
    m_small    = a_big ? {|b[C_OP-2 -: C_EXP], b[C_MANT-1:0]} : {|a[C_OP-2 -: C_EXP], a[C_MANT-1:0]};
    e_diff     = e_big - e_small;
    m_align    = m_small >> e_diff;

    if (sign_big == sign_small) m_sum = {1'b0, m_big} + {1'b0, m_align};
    else                        m_sum = {1'b0, m_big} - {1'b0, m_align};

    lz    = 0;
    found = 1'b0;
    for (int i = C_MANT; i >= 0; i--) begin
      if (!found && m_sum[i]) begin
        found = 1'b1;
        lz    = C_MANT - i;
      end
    end

    // exponent under/overflow wraps; there is no special-value handling
    if (m_sum[C_MANT+1]) begin
      m_norm = m_sum[C_MANT+1:1];
      e_norm = e_big + 1'b1;
    end else if (!found) begin
      m_norm = '0;
      e_norm = '0;
    end else begin
      m_norm = m_sum[C_MANT:0] << lz;
      e_norm = e_big - C_EXP'(lz);
    end

    sum = {sign_big, e_norm, m_norm[C_MANT-1:0]};
  end
endmodule

// state | meaning
// IDLE  | no group open; next accepted beat loads the accumulator
// ACCUM | group open; accepted beats are added into the accumulator
// HOLD  | group sum presented on the output until consumed
module fp_accumulator #(
  parameter int C_OP   = fp_defs::C_OP,
  parameter int C_EXP  = fp_defs::C_EXP,
  parameter int C_MANT = fp_defs::C_MANT,
  parameter int C_CNT  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [C_OP-1:0]  in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [C_OP-1:0]  out_data_o,
  output logic [C_CNT-1:0] out_count_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [C_OP-1:0]   acc_q, acc_d, sum;
  logic [C_CNT-1:0]  cnt_q, cnt_d;
  logic              accept, consume;

  fp_add #(.C_OP(C_OP), .C_EXP(C_EXP), .C_MANT(C_MANT)) u_add (
    .a   (acc_q),
    .b   (in_data_i),
    .sum (sum)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_o  = (state_q == S_HOLD) ? out_ready_i : 1'b1;
    out_valid_o = (state_q == S_HOLD);
    accept      = in_valid_i && in_ready_o;
    consume     = out_valid_o && out_ready_i;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = in_data_i;
          cnt_d   = C_CNT'(1);
          state_d = in_last_i ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_d   = sum;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          state_d = in_last_i ? S_HOLD : S_ACCUM;
        end
      end
      S_HOLD: begin
        // a beat arriving with the consume starts the next group without a bubble
        if (consume) begin
          if (accept) begin
            acc_d   = in_data_i;
            cnt_d   = C_CNT'(1);
            state_d = in_last_i ? S_HOLD : S_ACCUM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_data_o  = acc_q;
  assign out_count_o = cnt_q;
  assign busy_o      = (state_q != S_IDLE);
endmodule

// File: tb/tb_fp_accumulator.sv
// Testbench for fp_accumulator: directed scenarios plus randomized groups checked
// against an integer-arithmetic model of the FP adder rules.
module tb_fp_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_data, out_count;
  logic        s_in_ready, s_out_valid, s_busy;
  logic [15:0] s_out_data;
  logic [1:0]  s_out_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_accumulator dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_count_o(out_count), .busy_o(busy)
  );

  fp_accumulator #(.C_CNT(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(s_out_valid),
    .out_ready_i(out_ready), .out_data_o(s_out_data), .out_count_o(s_out_count), .busy_o(s_busy)
  );

  // Value = mant * 2^exp with hidden bit = (exp != 0); smaller operand aligned with
  // truncation, result normalised to [1024, 2048) by truncation, exponent modulo 32.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, e, mbig, msmall, d, s;
    bit sbig, ssmall;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    ma = int'(a[9:0]) + ((ea != 0) ? 1024 : 0);
    mb = int'(b[9:0]) + ((eb != 0) ? 1024 : 0);
    if (int'(a[14:0]) >= int'(b[14:0])) begin
      e = ea; mbig = ma; msmall = mb; d = ea - eb; sbig = a[15]; ssmall = b[15];
    end else begin
      e = eb; mbig = mb; msmall = ma; d = eb - ea; sbig = b[15]; ssmall = a[15];
    end
    msmall = (d > 11) ? 0 : msmall / (1 << d);
    s = (sbig == ssmall) ? mbig + msmall : mbig - msmall;
    if (s == 0) return {sbig, 15'b0};
    if (s >= 2048) begin s = s / 2; e = e + 1; end
    while (s < 1024) begin s = s * 2; e = e - 1; end
    return {sbig, 5'(e & 31), 10'(s % 1024)};
  endfunction

  function automatic logic [15:0] rand_op();
    return {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
  endfunction

  task automatic drive_beat(input logic [15:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", out_data); end
    checks++; if (out_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", out_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL post_reset: valid=%b busy=%b ready=%b want 0 0 1", out_valid, busy, in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_beat(16'h3C00, 1'b0);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL basic_accum: valid=%b busy=%b want 0 1", out_valid, busy); end
    drive_beat(16'h4000, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_no_early_valid: got %b want 0", out_valid); end
    drive_beat(16'h4200, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 16'h4600) begin errors++; $display("FAIL basic_data: got %h want 4600", out_data); end
    checks++; if (out_count !== 16'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", out_count); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL basic_one_cycle: valid=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive_beat(16'h4100, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h4100 || out_count !== 16'd1)
      begin errors++; $display("FAIL single: valid=%b data=%h count=%0d want 1 4100 1", out_valid, out_data, out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_beat(16'h4100, 1'b0);
    drive_beat(16'hB800, 1'b1);
    in_valid = 1'b1; in_data = 16'h7777; in_last = 1'b1;
    repeat (5) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h4000 || out_count !== 16'd2)
        begin errors++; $display("FAIL bp_hold: valid=%b data=%h count=%0d want 1 4000 2", out_valid, out_data, out_count); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_follow: got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_consume: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive_beat(16'h3C00, 1'b0);
    drive_beat(16'h4000, 1'b0);
    drive_beat(16'h4200, 1'b1);
    checks++; if (out_data !== 16'h4600 || out_valid !== 1'b1)
      begin errors++; $display("FAIL b2b_first: valid=%b data=%h want 1 4600", out_valid, out_data); end
    drive_beat(16'h3C00, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h3C00 || out_count !== 16'd1 || busy !== 1'b1)
      begin errors++; $display("FAIL b2b_second: valid=%b data=%h count=%0d busy=%b want 1 3c00 1 1", out_valid, out_data, out_count, busy); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_consume: got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive_beat(16'h3C00, 1'b0);
    drive_beat(16'h4000, 1'b0);
    #3 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_count !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL async_reset: valid=%b data=%h count=%0d busy=%b ready=%b want 0 0000 0 0 1",
                               out_valid, out_data, out_count, busy, in_ready); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    drive_beat(16'h3C00, 1'b0);
    drive_beat(16'h3C00, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h4000 || out_count !== 16'd2)
      begin errors++; $display("FAIL after_reset_group: valid=%b data=%h count=%0d want 1 4000 2", out_valid, out_data, out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    logic [15:0] expd;
    out_ready = 1'b1;
    expd = 16'h3C00;
    for (int k = 1; k < 5; k++) expd = ref_add(expd, 16'h3C00);
    for (int k = 0; k < 5; k++) drive_beat(16'h3C00, k == 4);
    checks++; if (s_out_valid !== 1'b1 || s_out_count !== 2'd3)
      begin errors++; $display("FAIL sat_count: valid=%b count=%0d want 1 3", s_out_valid, s_out_count); end
    checks++; if (s_out_data !== expd) begin errors++; $display("FAIL sat_data: got %h want %h", s_out_data, expd); end
    checks++; if (out_count !== 16'd5 || out_data !== expd)
      begin errors++; $display("FAIL wide_count: count=%0d data=%h want 5 %h", out_count, out_data, expd); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [15:0] op, cur;
    int n;
    bit pending;
    pending = 0;
    cur = '0;
    for (int g = 0; g < 60; g++) begin
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) begin
        op = rand_op();
        if (!(pending && k == 0)) begin
          out_ready = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0; in_data = 16'($urandom); in_last = 1'($urandom); out_ready = 1'($urandom);
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_gap_valid: g=%0d got %b want 0", g, out_valid); end
          end
        end else begin
          out_ready = 1'b1;
        end
        cur = (k == 0) ? op : ref_add(cur, op);
        drive_beat(op, k == n - 1);
        pending = 0;
      end
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== cur || out_count !== 16'(n))
        begin errors++; $display("FAIL rnd_sum: g=%0d valid=%b data=%h count=%0d want 1 %h %0d", g, out_valid, out_data, out_count, cur, n); end
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'($urandom); in_data = 16'($urandom); in_last = 1'($urandom);
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== cur || out_count !== 16'(n))
          begin errors++; $display("FAIL rnd_stall: g=%0d ready=%b valid=%b data=%h count=%0d want 0 1 %h %0d", g, in_ready, out_valid, out_data, out_count, cur, n); end
      end
      in_valid = 1'b0; in_last = 1'b0;
      if ($urandom_range(0, 1) == 1) pending = 1;
      else begin
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_consume: g=%0d got %b want 0", g, out_valid); end
        out_ready = 1'b0;
      end
    end
    if (pending) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_final_consume: got %b want 0", out_valid); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
